axi4lite_mst: RTL and testbench

AXI4LITE_MST -- requirements
Module: axi4lite_mst

---
 rtl/axi4lite_mst.sv | 129 ++++++++++++
 tb/tb_axi4lite_mst.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mst.sv
// AXI4-Lite master: turns one command at a time into an AW/W/B or AR/R exchange
// and hands the slave's response back on a valid/ready result port.
module axi4lite_mst #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_aclk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LO_MASK = ADDR_WIDTH'(3);

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_aw_done, r_w_done;
  logic                    r_rsp_write;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic                    w_accept, w_aw_hs, w_w_hs;

  // All handshake outputs decode straight from registered state, so no VALID
  // ever waits on a READY and the READYs come up on state entry.
  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_awvalid   = (r_state == S_WR_REQ) && !r_aw_done;
  assign o_wvalid    = (r_state == S_WR_REQ) && !r_w_done;
  assign o_bready    = (r_state == S_WR_RESP);
  assign o_arvalid   = (r_state == S_RD_REQ);
  assign o_rready    = (r_state == S_RD_RESP);
  assign o_rsp_valid = (r_state == S_RSP);

  assign o_awaddr    = r_addr;
  assign o_araddr    = r_addr;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_rsp_write = r_rsp_write;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;

  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_aw_hs  = o_awvalid && i_awready;
  assign w_w_hs   = o_wvalid && i_wready;

  always_ff @(posedge i_aclk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_cmd_valid) w_next = i_cmd_write ? S_WR_REQ : S_RD_REQ;
      // AW and W complete independently; leave once both are in, whichever order.
      S_WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_RESP;
      S_WR_RESP: if (i_bvalid)    w_next = S_RSP;
      S_RD_REQ:  if (i_arready)   w_next = S_RD_RESP;
      S_RD_RESP: if (i_rvalid)    w_next = S_RSP;
      S_RSP:     if (i_rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      if (w_accept) begin
        r_addr    <= i_cmd_addr & ~LO_MASK;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      // Writes leave rsp_rdata untouched so it still shows the last read.
      if (o_bready && i_bvalid) begin
        r_rsp_resp  <= i_bresp;
        r_rsp_write <= 1'b1;
      end
      if (o_rready && i_rvalid) begin
        r_rsp_resp  <= i_rresp;
        r_rsp_rdata <= i_rdata;
        r_rsp_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_mst.sv
// Bench for axi4lite_mst: behavioural 4-register slave (SLVERR at 0x10 and up),
// handshake monitor, table of commands with a scoreboard of expected responses.
module tb_axi4lite_mst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi4lite_mst #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .i_aclk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  // ---------------- slave model ----------------
  int          aw_lat, w_lat;
  logic        b_hold;
  int          aw_cnt, w_cnt;
  logic        got_aw, got_w, t_aw, t_w;
  logic [4:0]  s_addr, t_addr;
  logic [31:0] s_data, t_data;
  logic [3:0]  s_strb, t_strb;
  logic [31:0] mem [0:3] = '{default: 32'h0};

  assign awready = (aw_cnt >= aw_lat);
  assign wready  = (w_cnt >= w_lat);
  assign arready = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
      if (wvalid)  w_cnt  <= wready  ? 0 : w_cnt + 1;
      t_aw   = got_aw || (awvalid && awready);
      t_w    = got_w  || (wvalid && wready);
      t_addr = got_aw ? s_addr : awaddr;
      t_data = got_w  ? s_data : wdata;
      t_strb = got_w  ? s_strb : wstrb;
      if (awvalid && awready) begin got_aw <= 1'b1; s_addr <= awaddr; end
      if (wvalid && wready) begin got_w <= 1'b1; s_data <= wdata; s_strb <= wstrb; end
      if (t_aw && t_w) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        if (t_addr[4]) bresp <= 2'b10;
        else begin
          bresp <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (t_strb[b]) mem[t_addr[3:2]][8*b +: 8] <= t_data[8*b +: 8];
        end
        if (!b_hold) bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= araddr[4] ? 2'b10 : 2'b00;
        rdata  <= araddr[4] ? 32'h0 : mem[araddr[3:2]];
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- handshake monitor ----------------
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_hi_n = 0, ar_hi_n = 0, proto_err = 0;
  logic aw_pend, w_pend, ar_pend;
  logic [4:0]  aw_q, ar_q;
  logic [35:0] w_q;

  always @(posedge clk) begin
    if (rst) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
    end else begin
      aw_hs_n <= aw_hs_n + int'(awvalid && awready);
      w_hs_n  <= w_hs_n  + int'(wvalid && wready);
      b_hs_n  <= b_hs_n  + int'(bvalid && bready);
      ar_hs_n <= ar_hs_n + int'(arvalid && arready);
      r_hs_n  <= r_hs_n  + int'(rvalid && rready);
      aw_hi_n <= aw_hi_n + int'(awvalid);
      ar_hi_n <= ar_hi_n + int'(arvalid);
      if ((aw_pend && (!awvalid || awaddr != aw_q)) ||
          (w_pend && (!wvalid || {wdata, wstrb} != w_q)) ||
          (ar_pend && (!arvalid || araddr != ar_q)))
        proto_err <= proto_err + 1;
      aw_pend <= awvalid && !awready; aw_q <= awaddr;
      w_pend  <= wvalid && !wready;   w_q  <= {wdata, wstrb};
      ar_pend <= arvalid && !arready; ar_q <= araddr;
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_lat;
    int          w_lat;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  vec_t tbl [10];
  int   n_cmp = 0, n_err = 0, busy_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, ".valids"}, 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'(0));
    chk({tag, ".rsp"}, 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
    chk({tag, ".regs"}, 64'({awaddr, araddr, wdata, wstrb}), 64'(0));
  endtask

  task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept: cmd_ready=0 after 50 cycles, expected 1");
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output int lat);
    exp_t e;
    logic [34:0] snap;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!rsp_valid && cmd_ready) busy_bad++;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: rsp_valid=0 after 100 cycles, expected 1");
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    snap = {rsp_write, rsp_resp, rsp_rdata};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("rsp_hold", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, snap}));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_underflow: response with empty scoreboard, expected none");
    end else begin
      e = sb.pop_front();
      chk("rsp_write", 64'(rsp_write), 64'(e.w));
      chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int aw0, w0, b0, ar0, r0, awh0, arh0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0; aw_lat = 0; w_lat = 0; b_hold = 1'b0;

    tbl[0] = '{1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h00000000};
    tbl[1] = '{1'b0, 5'h04, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'h08, 32'h12345678, 4'hF, 0, 3, 0, 2'b00, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'h08, 32'hAABBCCDD, 4'h5, 3, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 5'h08, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h12BB56DD};
    tbl[5] = '{1'b1, 5'h10, 32'h00000055, 4'hF, 0, 0, 0, 2'b10, 32'h12BB56DD};
    tbl[6] = '{1'b0, 5'h10, 32'h0,        4'h0, 0, 0, 0, 2'b10, 32'h00000000};
    tbl[7] = '{1'b0, 5'h06, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[8] = '{1'b0, 5'h0B, 32'h0,        4'h0, 0, 0, 5, 2'b00, 32'h12BB56DD};
    tbl[9] = '{1'b1, 5'h13, 32'h11111111, 4'hF, 0, 0, 0, 2'b10, 32'h12BB56DD};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      aw_lat = tbl[i].aw_lat; w_lat = tbl[i].w_lat;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
      awh0 = aw_hi_n; arh0 = ar_hi_n;
      sb.push_back('{tbl[i].wr, tbl[i].exp_resp, tbl[i].exp_rdata});
      send_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      wait_rsp(tbl[i].hold, lat);
      if (i == 0) chk("wr_latency", 64'(lat), 64'(3));
      if (tbl[i].wr) begin
        chk("aw_count", 64'(aw_hs_n - aw0), 64'(1));
        chk("w_count", 64'(w_hs_n - w0), 64'(1));
        chk("b_count", 64'(b_hs_n - b0), 64'(1));
        if (tbl[i].w_lat > 0) chk("awvalid_cycles", 64'(aw_hi_n - awh0), 64'(1));
      end else begin
        chk("arvalid_cycles", 64'(ar_hi_n - arh0), 64'(1));
        chk("r_count", 64'(r_hs_n - r0), 64'(1));
      end
    end
    aw_lat = 0; w_lat = 0;

    // Command held while busy must wait out the response, then be taken.
    sb.push_back('{1'b0, 2'b00, 32'h0});
    send_cmd(1'b0, 5'h0C, 32'h0, 4'h0);
    cmd_write = 1'b1; cmd_addr = 5'h0C; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    wait_rsp(3, lat);
    @(negedge clk);
    chk("held_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1 cmd_valid = 1'b0;
    sb.push_back('{1'b1, 2'b00, 32'h0});
    wait_rsp(0, lat);
    chk("held_wr_latency", 64'(lat), 64'(3));
    sb.push_back('{1'b0, 2'b00, 32'hCAFEF00D});
    send_cmd(1'b0, 5'h0C, 32'h0, 4'h0);
    wait_rsp(0, lat);

    // Reset while waiting for a B that never arrives.
    b_hold = 1'b1;
    send_cmd(1'b1, 5'h00, 32'h77777777, 4'hF);
    lat = 0;
    while (!bready && lat < 20) begin @(negedge clk); lat++; end
    chk("reached_wr_resp", 64'(bready), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0; b_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 64'({rsp_valid, cmd_ready}), 64'(1));
    end
    sb.push_back('{1'b0, 2'b00, 32'hDEADBEEF});
    send_cmd(1'b0, 5'h04, 32'h0, 4'h0);
    wait_rsp(0, lat);

    chk("protocol_stability", 64'(proto_err), 64'(0));
    chk("busy_cmd_ready", 64'(busy_bad), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
